// File: rtl/rx_stream_unpacker_if.sv
// Show-ahead FIFO read port between an RX sample FIFO and its consumer.
// No latency of its own: plain wires.
// The consumer pops the head word by raising fifo_rdreq while fifo_empty is low.
interface rx_stream_unpacker_if;
    logic [17:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;

    // FIFO side: presents the head word and empty flag, receives pops
    modport master (output fifo_q, output fifo_empty, input fifo_rdreq);
    // Consumer side: reads the head word and empty flag, issues pops
    modport slave  (input fifo_q, input fifo_empty, output fifo_rdreq);
endinterface

// File: rtl/rx_stream_unpacker.sv
// Decodes the packed {ch0, iq, data} RX stream into frames of up to 8 channel samples.
// Latency: ch_0..ch_7 and out_strobe update one cycle after the frame's last word is accepted.
// Backpressure: pops whenever enabled and the FIFO is non-empty; an empty FIFO simply stalls decoding.
module rx_stream_unpacker #(
    parameter int ERR_W = 16
) (
    input  logic             rxclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       channels,
    input  logic             bitwidth8,
    rx_stream_unpacker_if.slave fifo,
    output logic [15:0]      ch_0,
    output logic [15:0]      ch_1,
    output logic [15:0]      ch_2,
    output logic [15:0]      ch_3,
    output logic [15:0]      ch_4,
    output logic [15:0]      ch_5,
    output logic [15:0]      ch_6,
    output logic [15:0]      ch_7,
    output logic             out_strobe,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_count,
    output logic             in_sync
);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rd_req;
    logic [3:0]        idx;
    logic [3:0]        n_reg;
    logic              mode_reg;
    logic [7:0][15:0]  stage;
    logic [7:0][15:0]  stage_nxt;
    logic [7:0][15:0]  ch_q;
    logic [7:0][15:0]  ch_nxt;

    logic              accept;
    logic              w_ch0;
    logic              w_iq;
    logic [15:0]       w_dat;
    logic [3:0]        n_new;
    logic              n_ok;
    logic              word_ok;
    logic              start;
    logic              cont;
    logic              frame_err;
    logic              load;
    logic              done;
    logic [3:0]        wr_idx;
    logic              wr_mode;
    logic [3:0]        wr_n;
    logic [4:0]        lo_pos;
    logic [4:0]        hi_pos;
    logic [4:0]        pos;
    logic [4:0]        dec_cnt;

    assign fifo.fifo_rdreq = rd_req;
    assign ch_0 = ch_q[0];
    assign ch_1 = ch_q[1];
    assign ch_2 = ch_q[2];
    assign ch_3 = ch_q[3];
    assign ch_4 = ch_q[4];
    assign ch_5 = ch_q[5];
    assign ch_6 = ch_q[6];
    assign ch_7 = ch_q[7];

    // Word classification, staging write and frame-complete decode
    always_comb begin
        accept    = rd_req;
        w_ch0     = fifo.fifo_q[17];
        w_iq      = fifo.fifo_q[16];
        w_dat     = fifo.fifo_q[15:0];
        n_new     = bitwidth8 ? {1'b0, channels[3:1]} : channels;
        n_ok      = (n_new != 4'd0) && (n_new <= 4'd8);
        word_ok   = (w_ch0 == (idx == 4'd1)) && (w_iq == idx[0]);
        // Any accepted marker opens a new frame, even one that also flags an error
        start     = accept && w_ch0;
        cont      = accept && (state == RUN) && word_ok && !w_ch0;
        frame_err = accept && (state == RUN) && !word_ok;
        load      = (start && n_ok) || cont;

        wr_idx    = start ? 4'd1 : idx;
        wr_mode   = start ? bitwidth8 : mode_reg;
        wr_n      = start ? n_new : n_reg;

        lo_pos    = {wr_idx, 1'b0} - 5'd2;
        hi_pos    = lo_pos + 5'd1;
        pos       = {1'b0, wr_idx} - 5'd1;

        stage_nxt = start ? '0 : stage;
        if (wr_mode) begin
            // 8-bit packing: two byte samples per word, low byte first, left-justified
            if (lo_pos < 5'd8) stage_nxt[lo_pos[2:0]] = {w_dat[7:0], 8'h00};
            if (hi_pos < 5'd8) stage_nxt[hi_pos[2:0]] = {w_dat[15:8], 8'h00};
        end else begin
            if (pos < 5'd8) stage_nxt[pos[2:0]] = w_dat;
        end

        // An erroring marker never completes a frame, so strobe and error stay exclusive
        done    = load && (wr_idx == wr_n) && !frame_err;
        dec_cnt = wr_mode ? {wr_n, 1'b0} : {1'b0, wr_n};
        for (int i = 0; i < 8; i++) begin
            ch_nxt[i] = (5'(i) < dec_cnt) ? stage_nxt[i] : 16'h0000;
        end
    end

    // FSM state register
    always_ff @(posedge rxclk) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    // FSM next state: disable or a bad non-marker word drops back to hunting
    always_comb begin
        state_nxt = state;
        if (!enable)         state_nxt = HUNT;
        else if (start)      state_nxt = n_ok ? RUN : HUNT;
        else if (frame_err)  state_nxt = HUNT;
    end

    // FSM outputs
    always_comb begin
        rd_req  = enable && !fifo.fifo_empty;
        in_sync = (state == RUN);
    end

    // Frame datapath: index, latched config, staging, outputs and error counter
    always_ff @(posedge rxclk) begin
        if (reset) begin
            idx        <= 4'd0;
            n_reg      <= 4'd0;
            mode_reg   <= 1'b0;
            stage      <= '0;
            ch_q       <= '0;
            out_strobe <= 1'b0;
            sync_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            out_strobe <= done;
            sync_err   <= frame_err;
            if (frame_err && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;

            if (!enable) begin
                idx <= 4'd0;
            end else if (start) begin
                if (n_ok) begin
                    n_reg    <= n_new;
                    mode_reg <= bitwidth8;
                    stage    <= stage_nxt;
                    idx      <= (n_new == 4'd1) ? 4'd1 : 4'd2;
                end else begin
                    idx <= 4'd0;
                end
            end else if (cont) begin
                stage <= stage_nxt;
                idx   <= done ? 4'd1 : idx + 4'd1;
            end else if (frame_err) begin
                idx <= 4'd0;
            end

            if (done) ch_q <= ch_nxt;
        end
    end

endmodule
